uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 11 +
 rtl/cmd_timer.sv | 19 +
 rtl/uart_cmd_parser.sv | 88 ++++++++
 tb/tb_uart_cmd_parser.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame constants and FSM state encoding shared by the UART command parser
package uart_cmd_pkg;
    localparam logic [7:0] SOF    = 8'hA5;
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'h15;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CHK, ST_EXEC, ST_RESP0, ST_RESP1
    } state_t;
endpackage

// File: rtl/cmd_timer.sv
// cmd_timer: inter-byte timeout counter; idles at zero when disabled and flags TO_LIMIT-1
module cmd_timer #(
    parameter int TO_LIMIT = 1_000_000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TO_LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(TO_LIMIT - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk_100MHz or posedge reset)
        if (reset) cnt <= '0;
        else if (clear || !enable) cnt <= '0;
        else if (!expired) cnt <= cnt + W'(1);
    assign expired = enable && cnt == LAST;
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses 5-byte register read/write frames from an Rx FIFO and answers on a Tx FIFO
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int DBITS    = 8,
    parameter int REG_AW   = 4,
    parameter int TO_LIMIT = 1_000_000
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DBITS-1:0]  read_data,
    output logic              read_uart,
    input  logic              tx_full,
    output logic              write_uart,
    output logic [DBITS-1:0]  write_data,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [DBITS-1:0]  reg_wdata,
    input  logic [DBITS-1:0]  reg_rdata,
    output logic [7:0]        err_count,
    output logic              busy
);
    state_t state, state_nx;
    logic [DBITS-1:0] cmd_q, addr_q, data_q, chk_q, rd_q;
    logic rd_pend, in_frame, pop, push, timeout, expired, valid;
    assign in_frame   = state inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
    assign pop        = !reset && !rx_empty && (state == ST_IDLE || in_frame);
    // a byte arriving in the expiry cycle still counts, so pops win over timeout
    assign timeout    = in_frame && expired && rx_empty;
    assign push       = !tx_full && (state == ST_RESP0 || state == ST_RESP1);
    assign valid      = chk_q == (cmd_q ^ addr_q ^ data_q) && (cmd_q == CMD_WR || cmd_q == CMD_RD)
                        && (addr_q >> REG_AW) == '0;
    assign read_uart  = pop;
    assign write_uart = push;
    assign reg_we     = state == ST_EXEC && valid && cmd_q == CMD_WR;
    assign reg_addr   = addr_q[REG_AW-1:0];
    assign reg_wdata  = data_q;
    assign busy       = state != ST_IDLE;
    cmd_timer #(.TO_LIMIT(TO_LIMIT)) u_timer (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .clear(pop),
        .enable(in_frame),
        .expired(expired)
    );
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = (pop && read_data == SOF) ? ST_CMD : ST_IDLE;
            ST_CMD:   state_nx = pop ? ST_ADDR : (timeout ? ST_IDLE : ST_CMD);
            ST_ADDR:  state_nx = pop ? ST_DATA : (timeout ? ST_IDLE : ST_ADDR);
            ST_DATA:  state_nx = pop ? ST_CHK : (timeout ? ST_IDLE : ST_DATA);
            ST_CHK:   state_nx = pop ? ST_EXEC : (timeout ? ST_IDLE : ST_CHK);
            ST_EXEC:  state_nx = ST_RESP0;
            ST_RESP0: state_nx = push ? (rd_pend ? ST_RESP1 : ST_IDLE) : ST_RESP0;
            ST_RESP1: state_nx = push ? ST_IDLE : ST_RESP1;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            chk_q      <= '0;
            rd_q       <= '0;
            rd_pend    <= 1'b0;
            write_data <= '0;
            err_count  <= '0;
        end else begin
            state <= state_nx;
            if (pop && state == ST_CMD) cmd_q <= read_data;
            if (pop && state == ST_ADDR) addr_q <= read_data;
            if (pop && state == ST_DATA) data_q <= read_data;
            if (pop && state == ST_CHK) chk_q <= read_data;
            if (state == ST_EXEC) begin
                write_data <= valid ? ACK : NAK;
                rd_pend    <= valid && cmd_q == CMD_RD;
                if (valid && cmd_q == CMD_RD) rd_q <= reg_rdata;
            end
            if (push && state == ST_RESP0 && rd_pend) write_data <= rd_q;
            if (((state == ST_EXEC && !valid) || timeout) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random frames against a frame-level model with FIFO and register-bank responders
module tb_uart_cmd_parser;
    localparam int TO = 100;
    logic       clk_100MHz = 1'b0, reset = 1'b1, rx_empty = 1'b1, tx_full = 1'b0;
    logic [7:0] read_data = 8'h00, write_data, reg_wdata, reg_rdata, err_count;
    logic       read_uart, write_uart, reg_we, busy;
    logic [3:0] reg_addr;
    int checks = 0, failures = 0, viol = 0, cyc = 0, pop_cyc = 0, push_cyc = 0, merr = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx_got[$];
    logic [11:0] we_got[$];
    logic [7:0]  bank[16];
    logic [7:0]  mregs[16];

    uart_cmd_parser #(.TO_LIMIT(TO)) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .rx_empty(rx_empty),
        .read_data(read_data),
        .read_uart(read_uart),
        .tx_full(tx_full),
        .write_uart(write_uart),
        .write_data(write_data),
        .reg_we(reg_we),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    assign reg_rdata = bank[reg_addr];

    // FIFO, Tx sink and register-bank responders
    always @(posedge clk_100MHz) begin
        cyc++;
        if (read_uart) begin
            if (rx_q.size() == 0) viol++;
            else begin
                void'(rx_q.pop_front());
                pop_cyc = cyc;
            end
        end
        if (write_uart) begin
            if (tx_full) viol++;
            if (tx_got.size() == 0) push_cyc = cyc;
            tx_got.push_back(write_data);
        end
        if (reg_we) begin
            we_got.push_back({reg_addr, reg_wdata});
            bank[reg_addr] = reg_wdata;
        end
        #1;
        rx_empty  = rx_q.size() == 0;
        read_data = rx_empty ? 8'h00 : rx_q[0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input int gap);
        @(negedge clk_100MHz);
        rx_q.push_back(b);
        repeat (gap) @(negedge clk_100MHz);
    endtask

    task automatic wait_rx_empty();
        int n = 0;
        while (n < 50 && rx_q.size() != 0) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("rx_drain", n < 50, 1);
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] k, input int gap_max, input int hold);
        logic [7:0]  exp_tx[$];
        logic [11:0] exp_we[$];
        logic [7:0]  fb[5];
        logic        v;
        int          n;
        v = ((c ^ a ^ d) == k) && (c == 8'h57 || c == 8'h52) && a < 8'd16;
        if (!v) begin
            exp_tx.push_back(8'h15);
            merr = (merr == 255) ? 255 : merr + 1;
        end else begin
            exp_tx.push_back(8'h06);
            if (c == 8'h52) exp_tx.push_back(mregs[a[3:0]]);
            else begin
                mregs[a[3:0]] = d;
                exp_we.push_back({a[3:0], d});
            end
        end
        fb[0] = 8'hA5; fb[1] = c; fb[2] = a; fb[3] = d; fb[4] = k;
        if (hold > 0) tx_full = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(fb[i], $urandom_range(0, gap_max));
        if (hold > 0) begin
            wait_rx_empty();
            repeat (hold) @(negedge clk_100MHz);
            chk("full_no_push", tx_got.size(), 0);
            chk("full_busy", busy, 1);
            tx_full = 1'b0;
        end
        n = 0;
        while (n < 300 && !(rx_q.size() == 0 && !busy && tx_got.size() >= exp_tx.size())) begin
            @(negedge clk_100MHz);
            n++;
        end
        chk("frame_done", n < 300, 1);
        chk("tx_len", tx_got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++) chk("tx_byte", tx_got[i], exp_tx[i]);
        chk("we_len", we_got.size(), exp_we.size());
        for (int i = 0; i < exp_we.size() && i < we_got.size(); i++) chk("we_addr_data", we_got[i], exp_we[i]);
        chk("err_count", err_count, merr);
        if (hold == 0 && tx_got.size() > 0) chk("latency", push_cyc - pop_cyc, 2);
        tx_got.delete();
        we_got.delete();
    endtask

    initial begin
        logic [7:0] c, a, d, k, g;
        for (int i = 0; i < 16; i++) begin
            bank[i]  = 8'h00;
            mregs[i] = 8'h00;
        end
        #1 rx_empty = 1'b0;
        read_data = 8'hA5;
        #2;
        chk("rst_read_uart", read_uart, 0);
        chk("rst_write_uart", write_uart, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_err_count", err_count, 0);
        repeat (3) @(negedge clk_100MHz);
        reset = 1'b0;

        frame(8'h57, 8'h03, 8'h3C, 8'h68, 0, 0);
        frame(8'h52, 8'h03, 8'h00, 8'h51, 0, 0);
        frame(8'h57, 8'h03, 8'h3C, 8'h69, 0, 0);
        frame(8'h57, 8'h10, 8'h00, 8'h47, 0, 0);
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        frame(8'h57, 8'h05, 8'hA5, 8'hF7, 1, 0);

        push_byte(8'hA5, 0);
        push_byte(8'h57, 0);
        wait_rx_empty();
        repeat (95) @(negedge clk_100MHz);
        chk("to_still_busy", busy, 1);
        repeat (10) @(negedge clk_100MHz);
        merr++;
        chk("to_idle", busy, 0);
        chk("to_err", err_count, merr);
        chk("to_no_tx", tx_got.size(), 0);
        frame(8'h52, 8'h05, 8'h00, 8'h57, 2, 0);

        frame(8'h52, 8'h03, 8'h00, 8'h51, 0, 20);

        for (int i = 0; i < 40; i++) begin
            g = 8'($urandom_range(0, 9));
            c = g < 4 ? 8'h57 : g < 8 ? 8'h52 : 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d = 8'($urandom);
            k = c ^ a ^ d ^ (($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                g = 8'($urandom);
                push_byte(g == 8'hA5 ? 8'h00 : g, $urandom_range(0, 2));
            end
            frame(c, a, d, k, 3, 0);
        end

        push_byte(8'hA5, 0);
        push_byte(8'h57, 0);
        push_byte(8'h03, 0);
        wait_rx_empty();
        @(posedge clk_100MHz);
        rx_q.push_back(8'h3C);
        #3;
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_read_uart", read_uart, 0);
        chk("mid_rst_write_uart", write_uart, 0);
        chk("mid_rst_reg_we", reg_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_write_data", write_data, 0);
        chk("mid_rst_reg_addr", reg_addr, 0);
        chk("mid_rst_reg_wdata", reg_wdata, 0);
        chk("mid_rst_err_count", err_count, 0);
        rx_q.delete();
        merr = 0;
        repeat (2) @(negedge clk_100MHz);
        reset = 1'b0;
        push_byte(8'h57, 0);
        frame(8'h57, 8'h0F, 8'h81, 8'hD9, 1, 0);
        frame(8'h52, 8'h0F, 8'h00, 8'h5D, 0, 0);

        for (int i = 0; i < 258; i++) frame(8'h00, 8'h01, 8'h02, 8'h03, 0, 0);
        chk("err_saturated", err_count, 255);
        chk("protocol_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
